// File: rtl/div_32.sv
// div_32: multicycle restoring divider for the execute stage, one quotient
// bit per cycle, with a cla_32 instance as the trial subtractor.
//
// Build option: define DIV_SIGNED_EN for two's-complement operands. Leave it
// undefined for unsigned operands; that build has no magnitude or sign logic.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous active-high reset
//   ctrl_div     start strobe, sampled only in IDLE
//   dividend     numerator, sampled with ctrl_div
//   divisor      denominator, sampled with ctrl_div
//   busy         high while a division is in RUN or DONE
//   result_rdy   one-cycle pulse when quotient/remainder are valid
//   quotient     registered quotient, held until the next completion
//   remainder    registered remainder, held until the next completion
//   div_by_zero  registered, set with a result whose divisor was zero
//
// cla_32: 32-bit adder with 4-bit lookahead groups and lookahead between groups.
//   x, y   addends
//   c0     carry in
//   s      sum
//   c_out  carry out

module cla_32 (
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        c0,
  output logic [31:0] s,
  output logic        c_out
);
  localparam int unsigned W  = 32;
  localparam int unsigned GW = 4;
  localparam int unsigned NG = W / GW;

  logic [W-1:0]  g;
  logic [W-1:0]  p;
  logic [W-1:0]  c;
  logic [NG-1:0] gg;
  logic [NG-1:0] gp;
  logic [NG:0]   gc;

  // Per-group generate/propagate, then bit carries from each group's carry-in.
  always_comb begin
    g     = x & y;
    p     = x ^ y;
    gg    = '0;
    gp    = '0;
    gc    = '0;
    c     = '0;
    gc[0] = c0;
    for (int k = 0; k < NG; k++) begin
      gg[k] = g[GW*k+3]
            | (p[GW*k+3] & g[GW*k+2])
            | (p[GW*k+3] & p[GW*k+2] & g[GW*k+1])
            | (p[GW*k+3] & p[GW*k+2] & p[GW*k+1] & g[GW*k]);
      gp[k] = p[GW*k+3] & p[GW*k+2] & p[GW*k+1] & p[GW*k];
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
      c[GW*k]   = gc[k];
      c[GW*k+1] = g[GW*k] | (p[GW*k] & gc[k]);
      c[GW*k+2] = g[GW*k+1]
                | (p[GW*k+1] & g[GW*k])
                | (p[GW*k+1] & p[GW*k] & gc[k]);
      c[GW*k+3] = g[GW*k+2]
                | (p[GW*k+2] & g[GW*k+1])
                | (p[GW*k+2] & p[GW*k+1] & g[GW*k])
                | (p[GW*k+2] & p[GW*k+1] & p[GW*k] & gc[k]);
    end
    s     = p ^ c;
    c_out = gc[NG];
  end
endmodule

module div_32 (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_div,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        result_rdy,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);
  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt;
  logic [W-1:0]  r_q;
  logic [W-1:0]  q_q;
  logic [W-1:0]  dvs_q;

  logic          dz_c;
  logic          last_c;
  logic [W-1:0]  dvd_mag_c;
  logic [W-1:0]  dvs_mag_c;
  logic [W-1:0]  r_sh_c;
  logic [W-1:0]  diff_c;
  logic          cout_c;
  logic          ok_c;
  logic [W-1:0]  r_nxt_c;
  logic [W-1:0]  q_nxt_c;
  logic [W-1:0]  q_fix_c;
  logic [W-1:0]  r_fix_c;

  assign dz_c   = (divisor == '0);
  assign last_c = (cnt == CW'(W - 1));

`ifdef DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;

  // Operand magnitudes; 0x80000000 maps to itself, which is correct unsigned.
  assign dvd_mag_c = dividend[W-1] ? (~dividend + W'(1)) : dividend;
  assign dvs_mag_c = divisor[W-1]  ? (~divisor  + W'(1)) : divisor;

  // Result signs are captured at the start edge along with the magnitudes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state_q == IDLE && ctrl_div) begin
      neg_q <= dividend[W-1] ^ divisor[W-1];
      neg_r <= dividend[W-1];
    end
  end

  assign q_fix_c = neg_q ? (~q_nxt_c + W'(1)) : q_nxt_c;
  assign r_fix_c = neg_r ? (~r_nxt_c + W'(1)) : r_nxt_c;
`else
  assign dvd_mag_c = dividend;
  assign dvs_mag_c = divisor;
  assign q_fix_c   = q_nxt_c;
  assign r_fix_c   = r_nxt_c;
`endif

  // One restoring step: shift {R,Q} left, subtract |divisor| as R + ~D + 1.
  // The bit shifted out of R[31] makes the trial succeed even without carry.
  assign r_sh_c = {r_q[W-2:0], q_q[W-1]};

  cla_32 u_sub (
    .x     (r_sh_c),
    .y     (~dvs_q),
    .c0    (1'b1),
    .s     (diff_c),
    .c_out (cout_c)
  );

  assign ok_c    = r_q[W-1] | cout_c;
  assign r_nxt_c = ok_c ? diff_c : r_sh_c;
  assign q_nxt_c = {q_q[W-2:0], ok_c};

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ctrl_div) state_d = dz_c ? DONE : RUN;
      RUN:     if (last_c)   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      r_q         <= '0;
      q_q         <= '0;
      dvs_q       <= '0;
      busy        <= 1'b0;
      result_rdy  <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      busy       <= (state_d != IDLE);
      result_rdy <= (state_d == DONE);
      unique case (state_q)
        IDLE: begin
          if (ctrl_div) begin
            r_q   <= '0;
            q_q   <= dvd_mag_c;
            dvs_q <= dvs_mag_c;
            cnt   <= '0;
            if (dz_c) begin
              quotient    <= '0;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        RUN: begin
          r_q <= r_nxt_c;
          q_q <= q_nxt_c;
          if (last_c) begin
            quotient    <= q_fix_c;
            remainder   <= r_fix_c;
            div_by_zero <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_div_32.sv
// Directed bench for div_32. Expected values are hand-computed; the signed
// vectors are used when DIV_SIGNED_EN is defined, unsigned vectors otherwise.
module tb_div_32;
  logic        clock;
  logic        reset;
  logic        ctrl_div;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        result_rdy;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_chk  = 0;
  int n_fail = 0;

  div_32 dut (
    .clock       (clock),
    .reset       (reset),
    .ctrl_div    (ctrl_div),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .result_rdy  (result_rdy),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Start a division and wait for result_rdy. lat counts edges after the start
  // edge E0 (0 = cycle after E0); -1 means no pulse within the budget.
  // Returns at the negedge inside the DONE cycle.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_low);
    @(negedge clock);
    ctrl_div = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clock);
    #1;
    ctrl_div = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    lat      = -1;
    busy_low = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      if (!busy) busy_low++;
      if (result_rdy) begin
        lat = n;
        break;
      end
      @(posedge clock);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ctrl_div = 1'b0;
    dividend = '0;
    divisor  = '0;
    #1;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_chk++; if (result_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy got %b want 0", result_rdy); end
    n_chk++; if (quotient !== 32'h0) begin n_fail++; $display("FAIL reset_q got %h want 0", quotient); end
    n_chk++; if (remainder !== 32'h0) begin n_fail++; $display("FAIL reset_r got %h want 0", remainder); end
    n_chk++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int lat, bl;
    do_div(32'd100, 32'd7, lat, bl);
    n_chk++; if (lat !== 32) begin n_fail++; $display("FAIL basic_lat got %0d want 32", lat); end
    n_chk++; if (bl !== 0) begin n_fail++; $display("FAIL basic_busy low_cycles %0d want 0", bl); end
    n_chk++; if (quotient !== 32'd14) begin n_fail++; $display("FAIL basic_q got %h want %h", quotient, 32'd14); end
    n_chk++; if (remainder !== 32'd2) begin n_fail++; $display("FAIL basic_r got %h want %h", remainder, 32'd2); end
    n_chk++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL basic_dbz got %b want 0", div_by_zero); end
    @(negedge clock);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle_busy got %b want 0", busy); end
    n_chk++; if (result_rdy !== 1'b0) begin n_fail++; $display("FAIL basic_rdy_pulse got %b want 0", result_rdy); end
    repeat (3) @(negedge clock);
    n_chk++; if (quotient !== 32'd14 || remainder !== 32'd2) begin
      n_fail++; $display("FAIL basic_hold got %h/%h want 0000000e/00000002", quotient, remainder);
    end
  endtask

`ifdef DIV_SIGNED_EN
  task automatic test_signed();
    int lat, bl;
    do_div(32'hFFFFFF9C, 32'd7, lat, bl);
    n_chk++; if (quotient !== 32'hFFFFFFF2 || remainder !== 32'hFFFFFFFE) begin
      n_fail++; $display("FAIL neg_dvd got %h/%h want fffffff2/fffffffe", quotient, remainder);
    end
    do_div(32'd100, 32'hFFFFFFF9, lat, bl);
    n_chk++; if (quotient !== 32'hFFFFFFF2 || remainder !== 32'd2) begin
      n_fail++; $display("FAIL neg_dvs got %h/%h want fffffff2/00000002", quotient, remainder);
    end
    do_div(32'h80000000, 32'hFFFFFFFF, lat, bl);
    n_chk++; if (quotient !== 32'h80000000 || remainder !== 32'h0 || div_by_zero !== 1'b0) begin
      n_fail++; $display("FAIL overflow got %h/%h/%b want 80000000/00000000/0", quotient, remainder, div_by_zero);
    end
    n_chk++; if (lat !== 32) begin n_fail++; $display("FAIL overflow_lat got %0d want 32", lat); end
  endtask
`else
  task automatic test_unsigned();
    int lat, bl;
    do_div(32'hFFFFFFFF, 32'h10, lat, bl);
    n_chk++; if (quotient !== 32'h0FFFFFFF || remainder !== 32'hF) begin
      n_fail++; $display("FAIL uns_div16 got %h/%h want 0fffffff/0000000f", quotient, remainder);
    end
    do_div(32'hFFFFFFFF, 32'h2, lat, bl);
    n_chk++; if (quotient !== 32'h7FFFFFFF || remainder !== 32'h1) begin
      n_fail++; $display("FAIL uns_div2 got %h/%h want 7fffffff/00000001", quotient, remainder);
    end
    do_div(32'h80000000, 32'hFFFFFFFF, lat, bl);
    n_chk++; if (quotient !== 32'h0 || remainder !== 32'h80000000) begin
      n_fail++; $display("FAIL uns_big_dvs got %h/%h want 00000000/80000000", quotient, remainder);
    end
    n_chk++; if (lat !== 32) begin n_fail++; $display("FAIL uns_lat got %0d want 32", lat); end
  endtask
`endif

  task automatic test_div_zero();
    int lat, bl;
    do_div(32'd12345, 32'd0, lat, bl);
    n_chk++; if (lat !== 0) begin n_fail++; $display("FAIL dz_lat got %0d want 0", lat); end
    n_chk++; if (quotient !== 32'h0 || remainder !== 32'd12345 || div_by_zero !== 1'b1) begin
      n_fail++; $display("FAIL dz_result got %h/%h/%b want 00000000/00003039/1", quotient, remainder, div_by_zero);
    end
    @(negedge clock);
    n_chk++; if (busy !== 1'b0 || result_rdy !== 1'b0) begin
      n_fail++; $display("FAIL dz_idle got busy %b rdy %b want 0 0", busy, result_rdy);
    end
    n_chk++; if (div_by_zero !== 1'b1 || remainder !== 32'd12345) begin
      n_fail++; $display("FAIL dz_hold got %b/%h want 1/00003039", div_by_zero, remainder);
    end
    // Raw remainder: the dividend is passed through unchanged in both builds.
    do_div(32'hFFFFFFFB, 32'd0, lat, bl);
    n_chk++; if (remainder !== 32'hFFFFFFFB || quotient !== 32'h0) begin
      n_fail++; $display("FAIL dz_raw got %h/%h want 00000000/fffffffb", quotient, remainder);
    end
    do_div(32'd8, 32'd2, lat, bl);
    n_chk++; if (quotient !== 32'd4 || remainder !== 32'd0 || div_by_zero !== 1'b0) begin
      n_fail++; $display("FAIL dz_clear got %h/%h/%b want 00000004/00000000/0", quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_start_while_busy();
    int lat, bl, rdy_cnt;
    logic [31:0] q_s, r_s;
    rdy_cnt = 0;
    lat = -1;
    q_s = '0;
    r_s = '0;
    @(negedge clock);
    ctrl_div = 1'b1;
    dividend = 32'd1000;
    divisor  = 32'd10;
    @(posedge clock);
    #1;
    ctrl_div = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      if (result_rdy) begin
        rdy_cnt++;
        if (lat < 0) begin lat = n; q_s = quotient; r_s = remainder; end
      end
      // Strobe presented so that edge E5 samples it while RUN.
      if (n == 4) begin ctrl_div = 1'b1; dividend = 32'd9; divisor = 32'd3; end
      if (n == 5) ctrl_div = 1'b0;
      @(posedge clock);
    end
    n_chk++; if (rdy_cnt !== 1) begin n_fail++; $display("FAIL busy_rdy_count got %0d want 1", rdy_cnt); end
    n_chk++; if (lat !== 32) begin n_fail++; $display("FAIL busy_lat got %0d want 32", lat); end
    n_chk++; if (q_s !== 32'd100 || r_s !== 32'd0) begin
      n_fail++; $display("FAIL busy_result got %h/%h want 00000064/00000000", q_s, r_s);
    end
    do_div(32'd9, 32'd3, lat, bl);
    n_chk++; if (quotient !== 32'd3 || remainder !== 32'd0) begin
      n_fail++; $display("FAIL busy_next got %h/%h want 00000003/00000000", quotient, remainder);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat, bl, rdy_cnt;
    rdy_cnt = 0;
    @(negedge clock);
    ctrl_div = 1'b1;
    dividend = 32'd8388608;
    divisor  = 32'd3;
    @(posedge clock);
    #1;
    ctrl_div = 1'b0;
    repeat (10) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    n_chk++; if (busy !== 1'b0 || result_rdy !== 1'b0 || quotient !== 32'h0 || remainder !== 32'h0 || div_by_zero !== 1'b0) begin
      n_fail++; $display("FAIL midrst_outputs got %b %b %h %h %b want all 0", busy, result_rdy, quotient, remainder, div_by_zero);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      if (result_rdy) rdy_cnt++;
    end
    n_chk++; if (rdy_cnt !== 0) begin n_fail++; $display("FAIL midrst_no_rdy got %0d want 0", rdy_cnt); end
    do_div(32'd8388608, 32'd3, lat, bl);
    n_chk++; if (quotient !== 32'd2796202 || remainder !== 32'd2) begin
      n_fail++; $display("FAIL midrst_redo got %h/%h want %h/00000002", quotient, remainder, 32'd2796202);
    end
    n_chk++; if (lat !== 32) begin n_fail++; $display("FAIL midrst_lat got %0d want 32", lat); end
  endtask

  initial begin
    test_reset();
    test_basic();
`ifdef DIV_SIGNED_EN
    test_signed();
`else
    test_unsigned();
`endif
    test_div_zero();
    test_start_while_busy();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/div_32.md
# div_32

Multicycle 32-bit integer divider for the pipeline processor's execute stage. It is the inverse counterpart of the `cla_32` adder and reuses one `cla_32` instance as its trial subtractor. A one-cycle `ctrl_div` pulse launches a division. The unit iterates one quotient bit per cycle (restoring algorithm), then presents quotient, remainder and a divide-by-zero flag with a one-cycle `result_rdy` pulse. The pipeline stalls on `busy`.

## Interface
Parameters: none (width fixed at 32).

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ctrl_div`  in  1  start strobe; sampled only in IDLE.
- `dividend`  in  32  numerator; sampled with `ctrl_div`.
- `divisor`  in  32  denominator; sampled with `ctrl_div`.
- `busy`  out  1  high in RUN and DONE.
- `result_rdy`  out  1  one-cycle pulse; outputs valid.
- `quotient`  out  32  registered quotient; holds until the next completion.
- `remainder`  out  32  registered remainder; holds until the next completion.
- `div_by_zero`  out  1  registered; set with a result whose divisor was 0.

## Operation
- **States:** IDLE, RUN, DONE. 5-bit iteration counter `cnt`.
- **IDLE:**
  - On an edge with `ctrl_div=1`, latch the operand magnitudes and the result signs (see Configuration).
  - Clear the partial remainder R (32 b) and load Q with |dividend|.
  - If `divisor==0`: go directly to DONE with `quotient=0`, `remainder=dividend` (raw) and `div_by_zero=1`.
  - Otherwise: `cnt=0`, go to RUN.
- **RUN:** each edge performs one iteration.
  - Shift {R,Q} left by 1. `ob` = the bit shifted out of R[31].
  - Trial-subtract with `cla_32`: x = shifted R, y = ~|divisor|, c0 = 1.
  - Success when `ob | Cout`. On success, R = sum and the new Q[0] = 1; otherwise R is unchanged and Q[0] = 0.
  - On the edge with `cnt==31`: apply the sign correction, write `quotient`/`remainder`, clear `div_by_zero`, go to DONE. Otherwise `cnt = cnt+1`.
- **DONE:** `result_rdy=1` for exactly this cycle. Next edge returns to IDLE.
- **Start strobe outside IDLE:** `ctrl_div` in RUN or DONE is ignored. It is not queued.
- **Division rule:** truncating toward zero; remainder takes the sign of the dividend.
- **Overflow:** 0x80000000 / 0xFFFFFFFF (signed) yields quotient 0x80000000, remainder 0, `div_by_zero=0`.
- **Operand changes:** changing `dividend`/`divisor` after the sampling edge has no effect.

## Timing
- **Reset values** (asynchronous, immediate): state = IDLE, `cnt=0`, `busy=0`, `result_rdy=0`, `quotient=0`, `remainder=0`, `div_by_zero=0`.
- **Normal latency:** with `ctrl_div` sampled at edge E0, `busy` rises after E0. `result_rdy` is high in the cycle after E32. The unit is back in IDLE after E33 and can accept a new start at E34.
- **Divide-by-zero latency:** `result_rdy` is high in the cycle after E0. Back in IDLE after E1.
- **Output stability:** `quotient`/`remainder`/`div_by_zero` change only on the completing edge (E32, or E0 for divide-by-zero). They are stable from then through every later cycle until the next completion.
- **Reset mid-operation:** any assertion of `reset` during RUN or DONE aborts immediately to the reset values. No `result_rdy` is produced for the aborted operation.
- **Throughput:** one division per 34 cycles (2 for divide-by-zero).

## Configuration
- Macro `DIV_SIGNED_EN`.
- **Defined:** operands are two's-complement signed.
  - Magnitudes are taken at the start edge.
  - The quotient is negated when the operand signs differ.
  - The remainder is negated when the dividend is negative.
- **Undefined:** operands are unsigned 32-bit; no magnitude or sign logic is built. 0xFFFFFFFF / 2 gives quotient 0x7FFFFFFF, remainder 1.
- **Either way:** latency, handshake and divide-by-zero behaviour are identical.

## Test plan
- **Basic positive** (`DIV_SIGNED_EN`): 100 / 7 → `result_rdy` in the cycle after E32; quotient 14, remainder 2; `busy` high from E0 through DONE.
- **Signed mix:** −100 / 7 → quotient −14 (0xFFFFFFF2), remainder −2 (0xFFFFFFFE). Then 100 / −7 → −14, 2. Then −2147483648 / −1 → 0x80000000, 0.
- **Divide by zero:** 12345 / 0 → `result_rdy` in the cycle after E0; quotient 0, remainder 12345, `div_by_zero=1`. A following 8 / 2 clears the flag, giving quotient 4.
- **Start while busy:** start 1000 / 10, then pulse `ctrl_div` with 9 / 3 at E5 → only one `result_rdy`, quotient 100, remainder 0. After E33, 9 / 3 → 3, 0.
- **Reset mid-run:** start 8388608 / 3; assert `reset` between E10 and E11 → all outputs 0 immediately and no `result_rdy`. After release, 8388608 / 3 → 2796202, remainder 2.
- **Unsigned build** (macro undefined): 0xFFFFFFFF / 0x10 → quotient 0x0FFFFFFF, remainder 0xF.
